// File: rtl/id_ex_pkg.sv
// Shared types for the decode / ID-EX stage: control bundle layout, opcodes,
// immediate formats and the canonical NOP word.
package id_ex_pkg;

  localparam int CTRL_W = 11;
  localparam logic [31:0] NOP_ENC = 32'h00000013;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_e;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_BRANCH = 7'b1100011,
    OP_IMM    = 7'b0010011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111
  } opcode_e;

  // Packed so that reg_write lands on bit 10 and result_src on bits 1:0.
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       jalr;
    logic       branch;
    logic       alu_src;
    logic [2:0] alu_control;
    logic [1:0] result_src;
  } ctrl_t;

endpackage

// File: rtl/controller.sv
// Main and ALU decoder: turns opcode/funct fields into the E-stage control
// bundle and selects the immediate format.
module controller
  import id_ex_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output ctrl_t      ctrl,
  output imm_src_e   imm_src
);

  logic [1:0] alu_op;

  always_comb begin
    ctrl    = '0;
    imm_src = IMM_I;
    alu_op  = 2'b00;
    case (op)
      OP_LOAD:   begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.result_src = 2'b01; end
      OP_STORE:  begin ctrl.mem_write = 1'b1; ctrl.alu_src = 1'b1; imm_src = IMM_S; end
      OP_RTYPE:  begin ctrl.reg_write = 1'b1; alu_op = 2'b10; end
      OP_BRANCH: begin ctrl.branch = 1'b1; imm_src = IMM_B; alu_op = 2'b01; end
      OP_IMM:    begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; alu_op = 2'b10; end
      OP_JAL:    begin ctrl.reg_write = 1'b1; ctrl.jump = 1'b1; ctrl.result_src = 2'b10; imm_src = IMM_J; end
      OP_JALR:   begin ctrl.reg_write = 1'b1; ctrl.jalr = 1'b1; ctrl.alu_src = 1'b1; ctrl.result_src = 2'b10; end
      OP_LUI:    begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; imm_src = IMM_U; end
      default:   ;
    endcase

    case (alu_op)
      2'b00: ctrl.alu_control = 3'b000;
      2'b01: ctrl.alu_control = 3'b001;
      default: begin
        case (funct3)
          // Only R-type with funct7[5] subtracts; addi never does.
          3'b000:  ctrl.alu_control = (op[5] && funct7_5) ? 3'b001 : 3'b000;
          3'b010:  ctrl.alu_control = 3'b101;
          3'b110:  ctrl.alu_control = 3'b011;
          3'b111:  ctrl.alu_control = 3'b010;
          default: ctrl.alu_control = 3'b000;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_fwd_mux.sv
// WB-to-D bypass select: substitutes the W-stage result when it writes the
// register being read (x0 never forwards).
module id_ex_fwd_mux #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs,
  input  logic [XLEN-1:0] rdata,
  input  logic            reg_write_w,
  input  logic [RA_W-1:0] rd_w,
  input  logic [XLEN-1:0] result_w,
  output logic [XLEN-1:0] data
);

  logic hit;

  assign hit  = reg_write_w && (rd_w != '0) && (rd_w == rs);
  assign data = hit ? result_w : rdata;

endmodule

// File: rtl/imm_extend.sv
// Builds the 32-bit sign-extended immediate for the selected instruction format.
module imm_extend
  import id_ex_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_src_e    imm_src,
  output logic [31:0] imm
);

  always_comb begin
    imm = {{20{instr[31]}}, instr[31:20]};
    case (imm_src)
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      default: ;
    endcase
  end

endmodule

// File: rtl/id_ex_pipe.sv
// Decode and ID/EX pipeline register with stall/flush, valid tracking,
// WB bypass on capture and operand refresh while stalled.
module id_ex_pipe
  import id_ex_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter int          RA_W      = 5,
  parameter bit          WB_BYPASS = 1'b1,
  parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [XLEN-1:0]   pc_plus4_d,
  input  logic              valid_d,
  input  logic [XLEN-1:0]   rd1_d,
  input  logic [XLEN-1:0]   rd2_d,
  input  logic              stall_e,
  input  logic              flush_e,
  input  logic              reg_write_w,
  input  logic [RA_W-1:0]   rd_w,
  input  logic [XLEN-1:0]   result_w,
  output logic [RA_W-1:0]   rs1_d,
  output logic [RA_W-1:0]   rs2_d,
  output logic [XLEN-1:0]   rd1_e,
  output logic [XLEN-1:0]   rd2_e,
  output logic [XLEN-1:0]   imm_ext_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [XLEN-1:0]   pc_plus4_e,
  output logic [31:0]       instr_e,
  output logic [RA_W-1:0]   rs1_e,
  output logic [RA_W-1:0]   rs2_e,
  output logic [RA_W-1:0]   rd_e,
  output logic              valid_e,
  output logic [CTRL_W-1:0] ctrl_e
);

  ctrl_t                  ctrl_dec;
  ctrl_t                  ctrl_ld;
  imm_src_e               imm_src;
  logic signed [31:0]     imm32;
  logic signed [XLEN-1:0] imm_x;
  logic [RA_W-1:0]        fwd_rs1, fwd_rs2;
  logic [XLEN-1:0]        fwd_base1, fwd_base2, fwd1, fwd2;

  assign rs1_d = RA_W'(instr_d[19:15]);
  assign rs2_d = RA_W'(instr_d[24:20]);

  controller u_ctrl (
    .op       (instr_d[6:0]),
    .funct3   (instr_d[14:12]),
    .funct7_5 (instr_d[30]),
    .ctrl     (ctrl_dec),
    .imm_src  (imm_src)
  );

  imm_extend u_imm (
    .instr   (instr_d[31:7]),
    .imm_src (imm_src),
    .imm     (imm32)
  );

  assign imm_x = XLEN'(imm32);

  always_comb begin
    ctrl_ld = ctrl_dec;
    if (instr_d[11:7] == 5'd0) ctrl_ld.reg_write = 1'b0;
  end

  // One mux per operand serves both paths: D-side fields on capture, the
  // held E-side fields while stalled.
  assign fwd_rs1   = stall_e ? rs1_e : rs1_d;
  assign fwd_rs2   = stall_e ? rs2_e : rs2_d;
  assign fwd_base1 = stall_e ? rd1_e : rd1_d;
  assign fwd_base2 = stall_e ? rd2_e : rd2_d;

  id_ex_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd1 (
    .rs (fwd_rs1), .rdata (fwd_base1), .reg_write_w (reg_write_w),
    .rd_w (rd_w), .result_w (result_w), .data (fwd1)
  );

  id_ex_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd2 (
    .rs (fwd_rs2), .rdata (fwd_base2), .reg_write_w (reg_write_w),
    .rd_w (rd_w), .result_w (result_w), .data (fwd2)
  );

  // D -> E register boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd1_e <= '0; rd2_e <= '0; imm_ext_e <= '0;
      pc_e <= '0; pc_plus4_e <= '0; instr_e <= NOP_INSTR;
      rs1_e <= '0; rs2_e <= '0; rd_e <= '0;
      valid_e <= 1'b0; ctrl_e <= '0;
    end else if (flush_e || (!stall_e && !valid_d)) begin
      // A bubble loaded from an invalid D slot still tracks the PC.
      rd1_e <= '0; rd2_e <= '0; imm_ext_e <= '0;
      pc_e       <= flush_e ? '0 : pc_d;
      pc_plus4_e <= flush_e ? '0 : pc_plus4_d;
      instr_e <= NOP_INSTR;
      rs1_e <= '0; rs2_e <= '0; rd_e <= '0;
      valid_e <= 1'b0; ctrl_e <= '0;
    end else if (stall_e) begin
      if (WB_BYPASS && valid_e) begin
        rd1_e <= fwd1;
        rd2_e <= fwd2;
      end
    end else begin
      rd1_e      <= WB_BYPASS ? fwd1 : rd1_d;
      rd2_e      <= WB_BYPASS ? fwd2 : rd2_d;
      imm_ext_e  <= imm_x;
      pc_e       <= pc_d;
      pc_plus4_e <= pc_plus4_d;
      instr_e    <= instr_d;
      rs1_e      <= rs1_d;
      rs2_e      <= rs2_d;
      rd_e       <= RA_W'(instr_d[11:7]);
      valid_e    <= 1'b1;
      ctrl_e     <= ctrl_ld;
    end
  end

endmodule
